// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: instruction format selectors, base opcodes,
// the canonical NOP word and a signed range helper for immediate checks.
package rv32_pkg;

    // Format selector values carried on the fmt port; 6 and 7 are illegal
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // True when v lies inside [lo, hi] as two's-complement values
    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/ins_enc_if.sv
// Field-set input and encoded-word output handshake bundle for ins_enc.
// master = producer of field sets and consumer of words; slave = encoder.
interface ins_enc_if #(parameter int ADDR_W = 32) ();

    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [2:0]        func3;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [6:0]        func7;
    logic [31:0]       imm;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    modport master (
        output in_valid, fmt, opcode, rd, func3, rs1, rs2, func7, imm, out_ready,
        input  in_ready, out_valid, out_word, out_addr, out_err
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, func3, rs1, rs2, func7, imm, out_ready,
        output in_ready, out_valid, out_word, out_addr, out_err
    );

endinterface

// File: rtl/ins_enc_pack.sv
// Combinational RV32I field packer. Illegal formats yield a NOP with err set.
// Optional macro INS_ENC_RANGE_CHECK_EN additionally flags immediates that do
// not fit the selected format; the word is still packed from truncated bits.
module ins_enc_pack
    import rv32_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  func3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  func7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        err
);

    logic fmt_err;
    logic range_err;

    // Place the fields for the selected format; unknown formats become a NOP
    always_comb begin
        word    = NOP_WORD;
        fmt_err = 1'b0;
        case (fmt_e'(fmt))
            FMT_R: word = {func7, rs2, rs1, func3, rd, opcode};
            FMT_I: word = {imm[11:0], rs1, func3, rd, opcode};
            FMT_S: word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
            FMT_B: word = {imm[12], imm[10:5], rs2, rs1, func3,
                           imm[4:1], imm[11], opcode};
            FMT_U: word = {imm[31:12], rd, opcode};
            FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: begin
                word    = NOP_WORD;
                fmt_err = 1'b1;
            end
        endcase
    end

`ifdef INS_ENC_RANGE_CHECK_EN
    // Flag immediates the selected format cannot represent exactly
    always_comb begin
        range_err = 1'b0;
        case (fmt_e'(fmt))
            FMT_I, FMT_S: range_err = !in_range(imm, -32'sd2048, 32'sd2047);
            FMT_B:        range_err = !in_range(imm, -32'sd4096, 32'sd4094) || imm[0];
            FMT_J:        range_err = !in_range(imm, -32'sd1048576, 32'sd1048574) || imm[0];
            FMT_U:        range_err = (imm[11:0] != 12'd0);
            default:      range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    assign err = fmt_err | range_err;

endmodule

// File: rtl/ins_enc.sv
// ins_enc: registered RV32I encoder. Packs a field set into a word, tags it
// with a running byte address and offers it on a valid/ready output stage.
// Optional macro INS_ENC_RANGE_CHECK_EN enables immediate range flagging.
module ins_enc
    import rv32_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    ins_enc_if.slave          bus,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [15:0]       count
);

    logic [31:0]       pack_word;
    logic              pack_err;
    logic              out_valid_q;
    logic [31:0]       out_word_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              out_err_q;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] word_addr;
    logic              accept;
    logic              handshake;

    ins_enc_pack u_pack (
        .fmt    (bus.fmt),
        .opcode (bus.opcode),
        .rd     (bus.rd),
        .func3  (bus.func3),
        .rs1    (bus.rs1),
        .rs2    (bus.rs2),
        .func7  (bus.func7),
        .imm    (bus.imm),
        .word   (pack_word),
        .err    (pack_err)
    );

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign handshake    = out_valid_q && bus.out_ready;
    assign word_addr    = load ? load_addr : addr_cnt;

    // Output register: capture on accept, drop valid once consumed
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_addr_q  <= '0;
            out_err_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_word_q  <= pack_word;
            out_addr_q  <= word_addr;
            out_err_q   <= pack_err;
        end else if (handshake) begin
            out_valid_q <= 1'b0;
        end
    end

    // Address counter: optional reload, then step past any accepted word
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_cnt <= BASE_ADDR;
        end else if (accept) begin
            addr_cnt <= word_addr + ADDR_W'(4);
        end else begin
            addr_cnt <= word_addr;
        end
    end

    // Emitted-word counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (handshake) begin
            count <= count + 16'd1;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_err   = out_err_q;

endmodule
